img_capture: RTL
================

Name: img_capture

Overview:
- Frame-capture sink for the video-style pixel stream made by the team's image sources: img_vsync/img_de/img_data, 8-bit grey pixels.
- Detects frame start, counts lines and columns, and writes every active pixel to a frame-buffer write port at a linear address.
- Checks frame geometry and reports errors; used at the output side of filter chains in simulation and on hardware.

Parameters:
- H_DISP, 640, active pixels per line.
- V_DISP, 480, active lines per frame.
- DW, 8, pixel width.
- AW, 19, write address width; must satisfy 2^AW >= H_DISP*V_DISP.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- cap_en  input  1  capture enable, level.
- err_clr  input  1  one-cycle pulse; clears sticky error flags.
- img_vsync  input  1  frame sync, active low.
- img_de  input  1  pixel valid.
- img_data  input  DW  pixel.
- wr_en  output  1  frame-buffer write strobe.
- wr_addr  output  AW  linear address, row*H_DISP+col.
- wr_data  output  DW  pixel to write.
- frame_start  output  1  one-cycle pulse when capture of a frame begins.
- frame_done  output  1  one-cycle pulse when V_DISP lines have been captured.
- frame_cnt  output  16  completed-frame count; wraps at 0xFFFF->0.
- err_hlen  output  1  sticky: a line had col count != H_DISP.
- err_vlen  output  1  sticky: frame had too few or too many lines, or an address overflow.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs are 0, the state is IDLE, and the counters (col, row, addr, frame_cnt) are 0.
- Input registration: img_vsync, img_de and img_data are registered once (vs_r, de_r, d_r). A previous-cycle copy gives the edges:
  - vs_fall = vs_r_prev & ~vs_r.
  - de_fall = de_r_prev & ~de_r.
- Write path: all outputs are registered. wr_en/wr_addr/wr_data appear exactly 2 cycles after the matching img_de/img_data at the ports.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - No writes.
  - When vs_fall and cap_en: go to ACTIVE, pulse frame_start, and set col=row=addr=0.
  - When vs_fall and !cap_en: ignored.
- ACTIVE:
  - Each cycle with de_r=1: wr_en=1, wr_addr=addr, wr_data=d_r, then addr++ and col++.
  - If addr would exceed H_DISP*V_DISP-1: suppress the write and set err_vlen.
  - On de_fall: if col != H_DISP set err_hlen; then row++ and col=0.
  - Addresses stay sequential even after a short or long line; there is no realignment.
  - On de_fall with row+1 == V_DISP: go to DONE, pulse frame_done, frame_cnt++.
  - On vs_fall in ACTIVE (short frame): set err_vlen, no frame_done, frame_cnt unchanged. Then, if cap_en, restart (frame_start pulse, counters cleared); otherwise go to IDLE.
- DONE:
  - de_r=1 (extra lines): set err_vlen, no writes.
  - On vs_fall: if cap_en, go to ACTIVE with frame_start and counters cleared; otherwise go to IDLE.
- Deasserting cap_en mid-frame: the current frame completes normally; capture stops at the next frame boundary.
- Errors:
  - Set has priority over err_clr in the same cycle.
  - Errors are not cleared by frame_start; only err_clr or reset clears them.
- Reset mid-frame: immediate return to IDLE. Capture needs a fresh vs_fall.
- A vs_fall coinciding with the last de_fall of a frame: the frame completes (frame_done), then the restart follows in the same cycle (frame_start also pulses).

Optional Feature:
- Macro: IMG_CAPTURE_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0].
  - A running sum of every written pixel (zero-extended, mod 2^32) is cleared at frame_start.
  - The sum is latched to checksum on the frame_done cycle; checksum reset value is 0.
- Undefined: no port and no accumulator logic.

Test Plan:
- Default params, 800x525 timing (sync 96/2, back porch 48/33), cap_en=1, data=addr[7:0]:
  - exactly 307200 wr_en.
  - wr_addr runs 0..307199 with wr_data==wr_addr[7:0].
  - one frame_start, one frame_done, frame_cnt=1, err_hlen=err_vlen=0.
- H_DISP=4, V_DISP=3, data 0x10..0x1B:
  - first wr_en 2 cycles after the first img_de.
  - addresses 0..11 with data 0x10..0x1B.
  - frame_done the cycle after the write of address 11.
- Second line only 3 pixels (H_DISP=4): err_hlen=1; 11 writes total, addresses 0..10; err_clr pulse then clears err_hlen to 0.
- vs_fall after 2 of 3 lines: err_vlen=1, no frame_done, frame_cnt stays 0, frame_start pulses again, next write at address 0.
- cap_en dropped during line 1 of a 4x3 frame: the frame completes (frame_cnt=1); the next frame produces no wr_en and no frame_start.
- IMG_CAPTURE_CHECKSUM_EN, 4x3 frame of all 0xFF: checksum=0x00000BF4 at frame_done; reset mid-frame returns checksum=0.

Source files
------------

// File: rtl/img_capture.sv
// Frame-capture sink: registers the vsync/de/data stream, writes active pixels to a linear frame-buffer port and checks frame geometry.
// Optional IMG_CAPTURE_CHECKSUM_EN adds a per-frame pixel checksum output.
module img_capture #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int DW     = 8,
  parameter int AW     = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_en,
  input  logic          err_clr,
  input  logic          img_vsync,
  input  logic          img_de,
  input  logic [DW-1:0] img_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          frame_start,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          err_hlen,
`ifdef IMG_CAPTURE_CHECKSUM_EN
  output logic [31:0]   checksum,
`endif
  output logic          err_vlen
);

  localparam int CW = $clog2(H_DISP + 2) + 1;
  localparam int RW = $clog2(V_DISP + 1);
  localparam logic [AW:0]   ADDR_END = (AW+1)'(H_DISP * V_DISP);
  localparam logic [CW-1:0] COL_FULL = CW'(H_DISP);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_DISP - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic          vs_r_q, vs_p_q, de_r_q, de_p_q;
  logic [DW-1:0] d_r_q;
  logic          vs_fall, de_fall, restart, last_row;

  logic          wr_en_q, wr_en_d, fs_q, fs_d, fd_q, fd_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW:0]   addr_q, addr_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          err_h_q, err_h_d, err_v_q, err_v_d, set_h, set_v;

  // Input stage plus one-cycle-old copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r_q <= 1'b0;
      vs_p_q <= 1'b0;
      de_r_q <= 1'b0;
      de_p_q <= 1'b0;
      d_r_q  <= '0;
    end else begin
      vs_r_q <= img_vsync;
      vs_p_q <= vs_r_q;
      de_r_q <= img_de;
      de_p_q <= de_r_q;
      d_r_q  <= img_data;
    end
  end

  assign vs_fall  = vs_p_q & ~vs_r_q;
  assign de_fall  = de_p_q & ~de_r_q;
  assign restart  = vs_fall & cap_en;
  assign last_row = (row_q == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A vsync fall always wins the next state, so a coincident last line completes then restarts
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (restart) state_d = ACTIVE;
      ACTIVE: begin
        if (de_fall && last_row) state_d = DONE;
        if (vs_fall)             state_d = cap_en ? ACTIVE : IDLE;
      end
      DONE:    if (vs_fall) state_d = cap_en ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    fcnt_d    = fcnt_q;
    set_h     = 1'b0;
    set_v     = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (de_r_q) begin
          if (addr_q < ADDR_END) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q[AW-1:0];
            wr_data_d = d_r_q;
            addr_d    = addr_q + (AW+1)'(1);
          end else begin
            set_v = 1'b1;
          end
          if (col_q != '1) col_d = col_q + CW'(1);
        end
        if (de_fall) begin
          if (col_q != COL_FULL) set_h = 1'b1;
          col_d = '0;
          row_d = row_q + RW'(1);
          if (last_row) begin
            fd_d   = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
          end
        end
        if (vs_fall && !(de_fall && last_row)) set_v = 1'b1;
      end
      DONE:    if (de_r_q) set_v = 1'b1;
      default: ;
    endcase
    if (restart) begin
      fs_d   = 1'b1;
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end
    err_h_d = set_h | (err_h_q & ~err_clr);
    err_v_d = set_v | (err_v_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      fcnt_q    <= '0;
      err_h_q   <= 1'b0;
      err_v_q   <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      fcnt_q    <= fcnt_d;
      err_h_q   <= err_h_d;
      err_v_q   <= err_v_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_cnt   = fcnt_q;
  assign err_hlen    = err_h_q;
  assign err_vlen    = err_v_q;

`ifdef IMG_CAPTURE_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, ck_q, ck_d;

  // frame_done never coincides with a write, so sum_q is already final when latched
  always_comb begin
    sum_d = sum_q;
    if (wr_en_d) sum_d = sum_q + 32'(d_r_q);
    if (restart) sum_d = '0;
    ck_d = fd_d ? sum_q : ck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ck_q  <= '0;
    end else begin
      sum_q <= sum_d;
      ck_q  <= ck_d;
    end
  end

  assign checksum = ck_q;
`endif

endmodule
